pic_nested: RTL and testbench
=============================

# pic_nested

Parametrised interrupt controller for the 16-bit core. It latches up to NIRQ request lines and applies a mask register and fixed priority. It tracks in-service state and delivers one vector at a time over the core's `irq` toggle / `irq_in` vector interface. It sits between the peripherals (timer, keyboard, vretrace) and the core, decodes its own I/O ports, and replaces the inline IRQ logic in the board top level.

## Interface
- NIRQ, 8: number of request lines, 1..8; line 0 has the highest priority.
- VEC_BASE, 8: vector for line n is VEC_BASE + n, computed 8-bit and wrapping.
- PORT_CMD, 16'h0020: command/status port.
- PORT_MASK, 16'h0021: mask port.
- GAP, 16: minimum number of clocks between two deliveries; must be ≥ 2.
- clock, in, 1: system clock (clock_25 domain).
- reset_n, in, 1: synchronous, active-low reset.
- irq_line, in, NIRQ: request lines, level; rising edges are latched.
- port_a, in, 16: I/O address.
- port_w, in, 1: I/O write strobe, one clock.
- port_r, in, 1: I/O read strobe, one clock.
- port_o, in, 8: I/O write data.
- port_i, out, 8: I/O read data, registered.
- irq, out, 1: toggles once per delivery.
- irq_in, out, 8: vector, valid from the clock `irq` toggles.
- isr_any, out, 1: high while any in-service bit is set; for debug LEDs.

## Operation
- Registers: IRR (pending), ISR (in service), IMR (mask, 1 = blocked), rsel (read select), prev (sampled irq_line), gap counter.
- Edge capture: a bit where irq_line=1 and prev=0 sets IRR[n]. prev is updated from irq_line every clock.
- Eligible set: IRR & ~IMR. Candidate: the lowest index in the eligible set.
- Delivery condition:
  - the gap counter is 0, and
  - the candidate is higher priority than every set ISR bit (nested mode), or ISR==0 (non-nested mode).
- On delivery:
  - IRR[c] cleared and ISR[c] set;
  - irq_in set to VEC_BASE+c and irq inverted;
  - gap counter loaded with GAP-1.
- The gap counter decrements to 0 and holds there.
- Writes to PORT_CMD:
  - port_o[7:5]=3'b001: non-specific EOI. Clears the highest-priority set ISR bit; no-op if ISR==0.
  - port_o[7:5]=3'b011: specific EOI. Clears ISR[port_o[2:0]]; ignored if the index is ≥ NIRQ.
  - port_o==8'h0A: rsel=IRR.
  - port_o==8'h0B: rsel=ISR.
  - Any other value is ignored.
- Writes to PORT_MASK: IMR ← port_o. Bits ≥ NIRQ are stored but have no effect. A mask write never clears IRR.
- Reads:
  - PORT_CMD returns IRR or ISR per rsel, zero-extended.
  - PORT_MASK returns IMR.
  - Any other address leaves port_i unchanged.
- Boundary rules:
  - Edge on line n in the same clock IRR[n] is delivered: IRR[n] stays set, so the request is re-queued.
  - Masked pending requests are held in IRR and delivered after unmasking.
  - Repeated edges while a bit is pending collapse into one request.
  - EOI in the same clock as a delivery: both take effect. The EOI acts on the ISR value before the delivery's set.
  - Reset mid-delivery: all state is cleared; no further toggle occurs.

## Timing
- Reset values:
  - irq=0, irq_in=0, port_i=0, isr_any=0;
  - IRR=0, ISR=0, IMR=0, rsel=IRR;
  - gap=0, prev=0.
- Request latency: line rises before edge k; IRR set at edge k; irq toggles at edge k+1 if eligible. This is a 2-clock minimum.
- Port read: port_r at edge k → port_i valid after edge k.
- Port write: takes effect at edge k and influences delivery from edge k+1.
- Back-to-back deliveries are spaced at least GAP clocks apart.

## Configuration
- PIC_NESTED_EN defined: a higher-priority request preempts the one in service (nested ISR stack, up to NIRQ deep).
- PIC_NESTED_EN undefined: only one request is in service at a time. Delivery requires ISR==0, and any EOI clears all of ISR.

## Structure
- Shared package holds:
  - default port constants PIC_PORT_CMD and PIC_PORT_MASK;
  - command codes PIC_OCW_EOI=3'b001, PIC_OCW_SEOI=3'b011, PIC_RD_IRR=8'h0A, PIC_RD_ISR=8'h0B.
- Sub-module pic_prio: combinational lowest-set-bit encoder for NIRQ bits, outputs {found, index}. It is used for candidate selection, for the ISR highest bit, and for non-specific EOI.

## Test plan
- Reset, then pulse irq_line[1] → irq toggles 2 clocks later with irq_in=9; a read of PORT_CMD after writing 0x0B returns 8'h02.
- IMR=8'h01, pulse line 0 → no toggle and IRR=8'h01; write IMR=0 → toggle with irq_in=8.
- Nested: line 2 in service, pulse line 0 → second toggle with irq_in=8 after ≥ GAP clocks, ISR=8'h05. Non-specific EOI → ISR=8'h04.
- Same as above without PIC_NESTED_EN → no second toggle until EOI. Then the toggle comes with irq_in=8 and ISR=8'h01.
- Lines 0 and 3 rise in the same clock → vector 8 first. The vector-11 toggle is withheld in nested mode until EOI. In non-nested mode it also follows EOI.
- Specific EOI 8'h67 with NIRQ=4 → ignored. Pulse a line during reset_n=0 → IRR stays 0 and irq stays 0.

Source files
------------

// File: rtl/pic_nested_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_nested_pkg
// Desc     : Shared port defaults and command codes for the pic_nested block.
// Revision : 1.0 - initial release
// ============================================================================
package pic_nested_pkg;

    localparam logic [15:0] PIC_PORT_CMD  = 16'h0020;
    localparam logic [15:0] PIC_PORT_MASK = 16'h0021;

    localparam logic [2:0]  PIC_OCW_EOI   = 3'b001;
    localparam logic [2:0]  PIC_OCW_SEOI  = 3'b011;
    localparam logic [7:0]  PIC_RD_IRR    = 8'h0A;
    localparam logic [7:0]  PIC_RD_ISR    = 8'h0B;

    typedef enum logic {
        RSEL_IRR = 1'b0,
        RSEL_ISR = 1'b1
    } rsel_e;

endpackage
`default_nettype wire

// File: rtl/pic_prio.sv
`default_nettype none
// ============================================================================
// Module   : pic_prio
// Desc     : Combinational lowest-set-bit encoder returning {found, index}.
// Revision : 1.0 - initial release
// ============================================================================
module pic_prio
    import pic_nested_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pic_nested.sv
`default_nettype none
// ============================================================================
// Module   : pic_nested
// Desc     : Edge-latched, masked, fixed-priority interrupt controller with
//            toggle/vector delivery. Define PIC_NESTED_EN for nested preemption.
// Revision : 1.0 - initial release
// ============================================================================
module pic_nested
    import pic_nested_pkg::*;
#(
    parameter int          NIRQ      = 8,
    parameter logic [7:0]  VEC_BASE  = 8'h08,
    parameter logic [15:0] PORT_CMD  = PIC_PORT_CMD,
    parameter logic [15:0] PORT_MASK = PIC_PORT_MASK,
    parameter int          GAP       = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NIRQ-1:0] irq_line,
    input  logic [15:0]     port_a,
    input  logic            port_w,
    input  logic            port_r,
    input  logic [7:0]      port_o,
    output logic [7:0]      port_i,
    output logic            irq,
    output logic [7:0]      irq_in,
    output logic            isr_any
);

    localparam int            IW       = (NIRQ > 1) ? $clog2(NIRQ) : 1;
    localparam int            GW       = $clog2(GAP);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);
`ifdef PIC_NESTED_EN
    localparam bit            NESTED   = 1'b1;
`else
    localparam bit            NESTED   = 1'b0;
`endif

    logic [NIRQ-1:0] irr_q, irr_d, isr_q, isr_d, prev_q;
    logic [7:0]      imr_q, imr_d, vec_q, vec_d, rd_q, rd_d;
    rsel_e           rsel_q, rsel_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            irq_q, irq_d;

    logic [NIRQ-1:0] w_edge, w_elig;
    logic            w_cand_found, w_isr_found, w_prio_ok, w_deliver;
    logic            w_cmd_wr, w_nseoi, w_seoi;
    logic [IW-1:0]   w_cand_idx, w_isr_idx;

    assign w_edge = irq_line & ~prev_q;
    assign w_elig = irr_q & ~imr_q[NIRQ-1:0];

    pic_prio #(.N(NIRQ), .IW(IW)) u_cand (
        .req_i   (w_elig),
        .found_o (w_cand_found),
        .idx_o   (w_cand_idx)
    );

    pic_prio #(.N(NIRQ), .IW(IW)) u_isr (
        .req_i   (isr_q),
        .found_o (w_isr_found),
        .idx_o   (w_isr_idx)
    );

    // Without nesting only an idle ISR admits a new delivery.
    assign w_prio_ok = !w_isr_found || (NESTED && (w_cand_idx < w_isr_idx));
    assign w_deliver = w_cand_found && (gap_q == '0) && w_prio_ok;

    assign w_cmd_wr  = port_w && (port_a == PORT_CMD);
    assign w_nseoi   = w_cmd_wr && (port_o[7:5] == PIC_OCW_EOI);
    assign w_seoi    = w_cmd_wr && (port_o[7:5] == PIC_OCW_SEOI)
                       && ({29'd0, port_o[2:0]} < 32'(NIRQ));

    always_comb begin
        irr_d  = irr_q;
        isr_d  = isr_q;
        imr_d  = imr_q;
        rsel_d = rsel_q;
        gap_d  = gap_q;
        irq_d  = irq_q;
        vec_d  = vec_q;
        rd_d   = rd_q;

        // EOI acts on the pre-delivery ISR; the delivery set is applied after.
        if (!NESTED && (w_nseoi || w_seoi)) begin
            isr_d = '0;
        end
        for (int i = 0; i < NIRQ; i++) begin
            if (NESTED && ((w_nseoi && w_isr_found && (w_isr_idx == IW'(i)))
                           || (w_seoi && (port_o[2:0] == 3'(i))))) begin
                isr_d[i] = 1'b0;
            end
            if (w_deliver && (w_cand_idx == IW'(i))) begin
                irr_d[i] = 1'b0;
                isr_d[i] = 1'b1;
            end
        end
        irr_d = irr_d | w_edge;

        if (w_cmd_wr && (port_o == PIC_RD_IRR)) begin
            rsel_d = RSEL_IRR;
        end else if (w_cmd_wr && (port_o == PIC_RD_ISR)) begin
            rsel_d = RSEL_ISR;
        end
        if (port_w && (port_a == PORT_MASK)) begin
            imr_d = port_o;
        end

        if (w_deliver) begin
            irq_d = ~irq_q;
            vec_d = VEC_BASE + 8'(w_cand_idx);
            gap_d = GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end

        if (port_r) begin
            if (port_a == PORT_CMD) begin
                rd_d = (rsel_q == RSEL_ISR) ? 8'(isr_q) : 8'(irr_q);
            end else if (port_a == PORT_MASK) begin
                rd_d = imr_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irr_q  <= '0;
            isr_q  <= '0;
            prev_q <= '0;
            imr_q  <= '0;
            vec_q  <= '0;
            rd_q   <= '0;
            rsel_q <= RSEL_IRR;
            gap_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            irr_q  <= irr_d;
            isr_q  <= isr_d;
            prev_q <= irq_line;
            imr_q  <= imr_d;
            vec_q  <= vec_d;
            rd_q   <= rd_d;
            rsel_q <= rsel_d;
            gap_q  <= gap_d;
            irq_q  <= irq_d;
        end
    end

    assign port_i  = rd_q;
    assign irq     = irq_q;
    assign irq_in  = vec_q;
    assign isr_any = |isr_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_nested.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_nested
// Desc     : Self-checking bench for pic_nested (NIRQ=6, GAP=4); honours PIC_NESTED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_nested;

    localparam int         N  = 6;
    localparam int         G  = 4;
    localparam logic [7:0] VB = 8'h08;
`ifdef PIC_NESTED_EN
    localparam bit NESTED = 1'b1;
`else
    localparam bit NESTED = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset_n;
    logic [N-1:0] irq_line;
    logic [15:0]  port_a;
    logic         port_w, port_r;
    logic [7:0]   port_o, port_i, irq_in;
    logic         irq, isr_any;

    always #5 clock = ~clock;

    pic_nested #(
        .NIRQ(N), .VEC_BASE(VB), .PORT_CMD(16'h0020), .PORT_MASK(16'h0021), .GAP(G)
    ) dut (
        .clock(clock), .reset_n(reset_n), .irq_line(irq_line),
        .port_a(port_a), .port_w(port_w), .port_r(port_r), .port_o(port_o),
        .port_i(port_i), .irq(irq), .irq_in(irq_in), .isr_any(isr_any)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: pending/in-service sets as bit arrays, gap as an integer.
    logic [N-1:0] m_irr, m_isr, m_prev;
    logic [7:0]   m_imr, m_vec, m_pi;
    logic         m_rsel, m_irq;
    int           m_gap;

    typedef struct packed {
        logic        rst_n;
        logic [5:0]  lines;
        logic [15:0] a;
        logic        w;
        logic        r;
        logic [7:0]  d;
        logic        e_irq;
        logic [7:0]  e_vec;
        logic [7:0]  e_pi;
        logic        e_any;
    } row_t;

    row_t tbl [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic rn, input logic [N-1:0] ln, input logic [15:0] a,
                        input logic w, input logic r, input logic [7:0] d);
        int cand, hi;
        logic ok;
        logic [N-1:0] nirr, nisr;
        reset_n = rn; irq_line = ln; port_a = a; port_w = w; port_r = r; port_o = d;
        if (!rn) begin
            m_irr = '0; m_isr = '0; m_prev = '0; m_imr = '0; m_vec = '0; m_pi = '0;
            m_rsel = 1'b0; m_irq = 1'b0; m_gap = 0;
        end else begin
            cand = -1;
            hi   = -1;
            for (int i = 0; i < N; i++) begin
                if (cand < 0 && m_irr[i] && !m_imr[i]) cand = i;
                if (hi < 0 && m_isr[i]) hi = i;
            end
            ok = (cand >= 0) && (m_gap == 0) && (NESTED ? (hi < 0 || cand < hi) : (hi < 0));
            if (r && a == 16'h0020) m_pi = m_rsel ? 8'(m_isr) : 8'(m_irr);
            else if (r && a == 16'h0021) m_pi = m_imr;
            nisr = m_isr;
            if (w && a == 16'h0020) begin
                if (d[7:5] == 3'b001) begin
                    if (!NESTED) nisr = '0;
                    else if (hi >= 0) nisr[hi] = 1'b0;
                end else if (d[7:5] == 3'b011 && int'(d[2:0]) < N) begin
                    if (!NESTED) nisr = '0;
                    else nisr[d[2:0]] = 1'b0;
                end else if (d == 8'h0A) m_rsel = 1'b0;
                else if (d == 8'h0B) m_rsel = 1'b1;
            end
            nirr = m_irr;
            if (ok) begin
                nirr[cand] = 1'b0;
                nisr[cand] = 1'b1;
                m_irq = ~m_irq;
                m_vec = VB + 8'(cand);
                m_gap = G - 1;
            end else if (m_gap > 0) begin
                m_gap--;
            end
            nirr = nirr | (ln & ~m_prev);
            if (w && a == 16'h0021) m_imr = d;
            m_irr = nirr; m_isr = nisr; m_prev = ln;
        end
        @(posedge clock);
        #1;
        check("model_irq", 32'(irq), 32'(m_irq));
        check("model_irq_in", 32'(irq_in), 32'(m_vec));
        check("model_port_i", 32'(port_i), 32'(m_pi));
        check("model_isr_any", 32'(isr_any), 32'(|m_isr));
    endtask

    task automatic idle();
        tick(1'b1, '0, 16'h0000, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_toggle(input int limit, output bit tog, output int n);
        logic start;
        start = irq;
        tog = 1'b0;
        n = 0;
        while (!tog && n < limit) begin
            idle();
            n++;
            if (irq !== start) tog = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          tog;
        int          n;
        logic [5:0]  lines_r;
        logic [15:0] ra;
        logic [7:0]  rd;

        reset_n = 1'b0; irq_line = '0; port_a = '0; port_w = 1'b0; port_r = 1'b0; port_o = '0;

        //          rst   lines  addr      w     r     data   irq   vec    pi     any
        tbl[0]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 6'h02, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 6'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 6'h00, 16'h0020, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 6'h02, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 6'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 8'h09, 8'h00, 1'b1};
        tbl[6]  = '{1'b1, 6'h00, 16'h0020, 1'b1, 1'b0, 8'h0B, 1'b1, 8'h09, 8'h00, 1'b1};
        tbl[7]  = '{1'b1, 6'h00, 16'h0020, 1'b0, 1'b1, 8'h00, 1'b1, 8'h09, 8'h02, 1'b1};
        tbl[8]  = '{1'b1, 6'h00, 16'h0021, 1'b1, 1'b0, 8'h01, 1'b1, 8'h09, 8'h02, 1'b1};
        tbl[9]  = '{1'b1, 6'h01, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 8'h09, 8'h02, 1'b1};
        tbl[10] = '{1'b1, 6'h00, 16'h0020, 1'b1, 1'b0, 8'h0A, 1'b1, 8'h09, 8'h02, 1'b1};
        tbl[11] = '{1'b1, 6'h00, 16'h0020, 1'b0, 1'b1, 8'h00, 1'b1, 8'h09, 8'h01, 1'b1};
        tbl[12] = '{1'b1, 6'h00, 16'h0020, 1'b1, 1'b0, 8'h20, 1'b1, 8'h09, 8'h01, 1'b0};
        tbl[13] = '{1'b1, 6'h00, 16'h0021, 1'b1, 1'b0, 8'h00, 1'b1, 8'h09, 8'h01, 1'b0};
        tbl[14] = '{1'b1, 6'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h08, 8'h01, 1'b1};
        tbl[15] = '{1'b1, 6'h00, 16'h0020, 1'b1, 1'b0, 8'h0B, 1'b0, 8'h08, 8'h01, 1'b1};
        tbl[16] = '{1'b1, 6'h00, 16'h0020, 1'b0, 1'b1, 8'h00, 1'b0, 8'h08, 8'h01, 1'b1};
        tbl[17] = '{1'b1, 6'h00, 16'h0020, 1'b1, 1'b0, 8'h67, 1'b0, 8'h08, 8'h01, 1'b1};
        tbl[18] = '{1'b1, 6'h00, 16'h0020, 1'b1, 1'b0, 8'h66, 1'b0, 8'h08, 8'h01, 1'b1};
        tbl[19] = '{1'b1, 6'h00, 16'h0020, 1'b0, 1'b1, 8'h00, 1'b0, 8'h08, 8'h01, 1'b1};
        tbl[20] = '{1'b1, 6'h00, 16'h0020, 1'b1, 1'b0, 8'h60, 1'b0, 8'h08, 8'h01, 1'b0};
        tbl[21] = '{1'b1, 6'h00, 16'h0020, 1'b0, 1'b1, 8'h00, 1'b0, 8'h08, 8'h00, 1'b0};
        tbl[22] = '{1'b1, 6'h00, 16'h0021, 1'b1, 1'b0, 8'hC0, 1'b0, 8'h08, 8'h00, 1'b0};
        tbl[23] = '{1'b1, 6'h04, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h08, 8'h00, 1'b0};
        tbl[24] = '{1'b1, 6'h00, 16'h0021, 1'b0, 1'b1, 8'h00, 1'b1, 8'h0A, 8'hC0, 1'b1};

        for (int i = 0; i < 25; i++) begin
            tick(tbl[i].rst_n, tbl[i].lines, tbl[i].a, tbl[i].w, tbl[i].r, tbl[i].d);
            check($sformatf("row%0d_irq", i), 32'(irq), 32'(tbl[i].e_irq));
            check($sformatf("row%0d_irq_in", i), 32'(irq_in), 32'(tbl[i].e_vec));
            check($sformatf("row%0d_port_i", i), 32'(port_i), 32'(tbl[i].e_pi));
            check($sformatf("row%0d_isr_any", i), 32'(isr_any), 32'(tbl[i].e_any));
        end

        // Line 2 is in service with the gap running; line 0 now requests.
        tick(1'b1, 6'h01, 16'h0000, 1'b0, 1'b0, 8'h00);
`ifdef PIC_NESTED_EN
        wait_toggle(12, tog, n);
        check("nest_toggle", 32'(tog), 32'd1);
        check("nest_spacing", 32'(n + 1), 32'(G));
        check("nest_vec", 32'(irq_in), 32'h08);
        tick(1'b1, '0, 16'h0020, 1'b0, 1'b1, 8'h00);
        check("nest_isr", 32'(port_i), 32'h05);
        tick(1'b1, '0, 16'h0020, 1'b1, 1'b0, 8'h20);
        tick(1'b1, '0, 16'h0020, 1'b0, 1'b1, 8'h00);
        check("nest_isr_after_eoi", 32'(port_i), 32'h04);
`else
        wait_toggle(12, tog, n);
        check("flat_hold", 32'(tog), 32'd0);
        tick(1'b1, '0, 16'h0020, 1'b1, 1'b0, 8'h20);
        wait_toggle(12, tog, n);
        check("flat_toggle", 32'(tog), 32'd1);
        check("flat_latency", 32'(n), 32'd1);
        check("flat_vec", 32'(irq_in), 32'h08);
        tick(1'b1, '0, 16'h0020, 1'b0, 1'b1, 8'h00);
        check("flat_isr", 32'(port_i), 32'h01);
`endif

        // Lines 0 and 3 rise together.
        tick(1'b0, '0, 16'h0000, 1'b0, 1'b0, 8'h00);
        idle();
        tick(1'b1, 6'h09, 16'h0000, 1'b0, 1'b0, 8'h00);
        idle();
        check("pair_first_irq", 32'(irq), 32'd1);
        check("pair_first_vec", 32'(irq_in), 32'h08);
        wait_toggle(12, tog, n);
        check("pair_hold", 32'(tog), 32'd0);
        tick(1'b1, '0, 16'h0020, 1'b1, 1'b0, 8'h20);
        wait_toggle(12, tog, n);
        check("pair_second_toggle", 32'(tog), 32'd1);
        check("pair_second_vec", 32'(irq_in), 32'h0B);

        lines_r = '0;
        for (int k = 0; k < 3000; k++) begin
            lines_r = lines_r ^ 6'($urandom & $urandom & $urandom);
            case ($urandom_range(0, 3))
                0, 2:    ra = 16'h0020;
                1:       ra = 16'h0021;
                default: ra = 16'h0022;
            endcase
            case ($urandom_range(0, 5))
                0:       rd = 8'h20;
                1:       rd = 8'h60 | 8'($urandom_range(0, 7));
                2:       rd = 8'h0A;
                3:       rd = 8'h0B;
                4:       rd = 8'($urandom & $urandom);
                default: rd = 8'($urandom);
            endcase
            tick($urandom_range(0, 299) != 0, lines_r, ra,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
